// File: rtl/insn_sequencer.sv
// insn_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM
// with memory handshakes, timeout supervision and a retire counter.
module insn_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir,
    input  logic             dec_reg_we,
    input  logic             dec_mem_we,
    input  logic             dec_mem_rd,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             rf_we,
    output logic             pc_en,
    output logic             busy,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [1:0] {
        C_NOP,
        C_ALU,
        C_LOAD,
        C_STORE
    } cls_t;

    state_t            state;
    state_t            state_nx;
    cls_t              cls;
    cls_t              cls_nx;
    logic [1:0]        fault_nx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timed_out;

    assign timed_out = (wait_cnt == WAIT_W'(TIMEOUT));

    // State, instruction class and fault registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cls   <= C_NOP;
            fault <= 2'b00;
        end else begin
            state <= state_nx;
            cls   <= cls_nx;
            fault <= fault_nx;
        end
    end

    // Next-state, classification and fault selection
    always_comb begin
        state_nx = state;
        cls_nx   = cls;
        fault_nx = fault;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    state_nx = S_DECODE;
                end else if (timed_out) begin
                    state_nx = S_HALT;
                    fault_nx = 2'b01;
                end
            end
            S_DECODE: begin
                case ({dec_mem_rd, dec_mem_we, dec_reg_we})
                    3'b101: begin
                        cls_nx   = C_LOAD;
                        state_nx = S_MEM;
                    end
                    3'b010: begin
                        cls_nx   = C_STORE;
                        state_nx = S_MEM;
                    end
                    3'b001: begin
                        cls_nx   = C_ALU;
                        state_nx = S_EXEC;
                    end
                    3'b000: begin
                        cls_nx   = C_NOP;
                        state_nx = S_WB;
                    end
                    default: begin
                        state_nx = S_HALT;
                        fault_nx = 2'b11;
                    end
                endcase
            end
            S_EXEC: state_nx = S_WB;
            S_MEM: begin
                if (dmem_ack) begin
                    state_nx = S_WB;
                end else if (timed_out) begin
                    state_nx = S_HALT;
                    fault_nx = 2'b10;
                end
            end
            S_WB:    state_nx = S_FETCH;
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_IDLE;
        endcase
    end

    // Wait counter: zero outside the request states, so it
    // starts at zero on every entry to FETCH or MEM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state != S_FETCH && state != S_MEM) begin
            wait_cnt <= '0;
        end else if (!timed_out) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Instruction register loads on the accepted fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir <= '0;
        end else if (state == S_FETCH && imem_ack) begin
            ir <= imem_rdata;
        end
    end

    // Retire counter bumps once per write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (state == S_WB) begin
            retired <= retired + 1'b1;
        end
    end

    assign imem_req = (state == S_FETCH);
    assign dmem_req = (state == S_MEM);
    assign dmem_we  = (state == S_MEM) && (cls == C_STORE);
    assign pc_en    = (state == S_WB);
    assign rf_we    = (state == S_WB) &&
                      (cls == C_LOAD || cls == C_ALU);
    assign busy     = (state != S_IDLE) && (state != S_HALT);

endmodule

// File: tb/tb_insn_sequencer.sv
// tb_insn_sequencer: randomized transaction-level reference
// model compared against insn_sequencer cycle by cycle.
module tb_insn_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        dec_reg_we;
    logic        dec_mem_we;
    logic        dec_mem_rd;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        rf_we;
    logic        pc_en;
    logic        busy;
    logic [1:0]  fault;
    logic [31:0] retired;

    insn_sequencer #(.TIMEOUT(TO), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .dec_reg_we (dec_reg_we),
        .dec_mem_we (dec_mem_we),
        .dec_mem_rd (dec_mem_rd),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .rf_we      (rf_we),
        .pc_en      (pc_en),
        .busy       (busy),
        .fault      (fault),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          rf_cnt = 0;
    int          pc_cnt = 0;
    logic [31:0] m_ir;
    logic [31:0] m_ret;
    logic [1:0]  m_fault;
    bit          halted;

    // instruction classes used by the model
    localparam int NOP = 0, ALU = 1, LD = 2, ST = 3, ILL = 4;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h",
                     tag, obs, exp);
        else
            n_pass++;
    endtask

    // check one cycle ({imem_req,dmem_req,dmem_we,rf_we,
    // pc_en,busy}), then drive inputs for the next edge
    task automatic cyc(input string tag,
                       input logic [5:0] ev,
                       input logic ia,
                       input logic da,
                       input logic [2:0] fl,
                       input logic [31:0] w);
        chk({tag, "_out"},
            {58'd0, imem_req, dmem_req, dmem_we,
             rf_we, pc_en, busy}, {58'd0, ev});
        chk({tag, "_ir"}, {32'd0, ir}, {32'd0, m_ir});
        chk({tag, "_ret"}, {32'd0, retired}, {32'd0, m_ret});
        chk({tag, "_fault"}, {62'd0, fault}, {62'd0, m_fault});
        if (rf_we) rf_cnt++;
        if (pc_en) pc_cnt++;
        imem_ack   = ia;
        dmem_ack   = da;
        {dec_mem_rd, dec_mem_we, dec_reg_we} = fl;
        imem_rdata = ia ? w : $urandom;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        start    = 1'b0;
        #1;
        m_ir     = '0;
        m_ret    = '0;
        m_fault  = 2'b00;
        halted   = 1'b0;
        cyc("rst", 6'b0, 1'b0, 1'b0, 3'b0, 0);
        rst = 1'b0;
    endtask

    task automatic kick();
        start = 1'b0;
        cyc("idle", 6'b0, $urandom, $urandom, $urandom, 0);
        start = 1'b1;
        cyc("idle_go", 6'b0, $urandom, $urandom, $urandom, 0);
    endtask

    // f/d = cycles before ack in FETCH/MEM; > TO means none
    task automatic run_insn(input logic [31:0] w,
                            input int c,
                            input int f,
                            input int d);
        logic [2:0] fl;
        logic       rf;
        int         nf;
        int         nd;
        if (halted) return;
        nf = (f > TO) ? TO : f;
        for (int i = 0; i <= nf; i++)
            cyc("fetch", 6'b100001, (i == f), $urandom,
                $urandom, w);
        if (f > TO) begin
            m_fault = 2'b01;
            halted  = 1'b1;
            return;
        end
        m_ir = w;
        case (c)
            NOP:     fl = 3'b000;
            ALU:     fl = 3'b001;
            LD:      fl = 3'b101;
            ST:      fl = 3'b010;
            default: fl = 3'b110;
        endcase
        cyc("decode", 6'b000001, $urandom, $urandom, fl, 0);
        if (c == ILL) begin
            m_fault = 2'b11;
            halted  = 1'b1;
            return;
        end
        if (c == LD || c == ST) begin
            nd = (d > TO) ? TO : d;
            for (int i = 0; i <= nd; i++)
                cyc("mem", {2'b01, (c == ST), 3'b001},
                    $urandom, (i == d), $urandom, 0);
            if (d > TO) begin
                m_fault = 2'b10;
                halted  = 1'b1;
                return;
            end
        end else if (c == ALU) begin
            cyc("exec", 6'b000001, $urandom, $urandom,
                $urandom, 0);
        end
        rf = (c == LD || c == ALU);
        cyc("wb", {3'b000, rf, 2'b11}, $urandom, $urandom,
            $urandom, 0);
        m_ret = m_ret + 1;
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            start = $urandom;
            cyc("halt", 6'b0, $urandom, $urandom,
                $urandom, $urandom);
        end
    endtask

    function automatic int lat();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return TO;
        return $urandom_range(0, 3);
    endfunction

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        imem_ack   = 1'b0;
        dmem_ack   = 1'b0;
        imem_rdata = '0;
        dec_reg_we = 1'b0;
        dec_mem_we = 1'b0;
        dec_mem_rd = 1'b0;
        @(negedge clk);

        // load then store
        do_reset();
        kick();
        run_insn(32'h0000B083, LD, 0, 0);
        run_insn(32'h0010B023, ST, 0, 3);

        // 100 back-to-back ALU instructions
        do_reset();
        kick();
        rf_cnt = 0;
        pc_cnt = 0;
        for (int i = 0; i < 100; i++)
            run_insn($urandom, ALU, 0, 0);
        chk("alu_ret", {32'd0, retired}, 64'd100);
        chk("alu_rf_pulses", rf_cnt, 100);
        chk("alu_pc_pulses", pc_cnt, 100);

        // random legal mix incl. ack exactly at TIMEOUT
        do_reset();
        kick();
        run_insn($urandom, LD, TO, TO);
        for (int i = 0; i < 60; i++)
            run_insn($urandom, $urandom_range(0, 3),
                     lat(), lat());

        // reset in the middle of MEM
        do_reset();
        kick();
        run_insn($urandom, ALU, 1, 0);
        cyc("fetch", 6'b100001, 1'b1, 1'b0, 3'b0,
            32'h0000B083);
        m_ir = 32'h0000B083;
        cyc("decode", 6'b000001, 1'b0, 1'b0, 3'b101, 0);
        cyc("mem", 6'b010001, 1'b0, 1'b0, 3'b0, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_dreq", dmem_req, 0);
        chk("mid_rst_ir", ir, 0);
        chk("mid_rst_ret", retired, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        do_reset();
        kick();
        run_insn(32'h00A00093, ALU, 0, 0);

        // fetch timeout
        do_reset();
        kick();
        run_insn(32'h00000013, ALU, 0, 0);
        run_insn($urandom, ALU, TO + 1, 0);
        halt_cycles(6);

        // data timeout
        do_reset();
        kick();
        run_insn($urandom, ST, 2, TO + 1);
        halt_cycles(4);

        // illegal decode flags
        do_reset();
        kick();
        run_insn($urandom, NOP, 0, 0);
        run_insn(32'hDEADBEEF, ILL, 1, 0);
        halt_cycles(6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
